// File: rtl/mem_port_arbiter_if.sv
// Bundle of requester-side (IF/MEM stages) and memory-side signals around the
// shared memory port. The arbiter uses the slave view; the environment drives the master view.
interface mem_port_arbiter_if #(
  parameter int AW = 16,
  parameter int DW = 16
);
  // instruction fetch requester
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_rdata;
  logic          if_done;
  logic          if_stall;
  // data-memory stage requester
  logic          mem_rd;
  logic          mem_wr;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_done;
  logic          mem_stall;
  logic          halt;
  // memory side
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic          m_rd;
  logic          m_wr;
  logic          m_halt;
  logic [DW-1:0] m_rdata;
  logic          m_busy;
  logic          m_done;
  logic          err;

  modport slave (
    input  if_req, if_addr,
    output if_rdata, if_done, if_stall,
    input  mem_rd, mem_wr, mem_addr, mem_wdata, halt,
    output mem_rdata, mem_done, mem_stall,
    output m_addr, m_wdata, m_rd, m_wr, m_halt,
    input  m_rdata, m_busy, m_done,
    output err
  );

  modport master (
    output if_req, if_addr,
    input  if_rdata, if_done, if_stall,
    output mem_rd, mem_wr, mem_addr, mem_wdata, halt,
    input  mem_rdata, mem_done, mem_stall,
    input  m_addr, m_wdata, m_rd, m_wr, m_halt,
    output m_rdata, m_busy, m_done,
    input  err
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported, variable-latency memory between instruction fetch and
// the data-memory stage: issue / accept / wait-for-done sequencing with anti-starvation.
module mem_port_arbiter #(
  parameter int AW    = 16,
  parameter int DW    = 16,
  parameter int TMO_W = 5
) (
  input  logic                clk,
  input  logic                rst_n,
  mem_port_arbiter_if.slave   bus
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RESP
  } state_t;

  localparam logic             OWN_IF   = 1'b0;
  localparam logic             OWN_MEM  = 1'b1;
  localparam logic [TMO_W-1:0] TMO_MAX  = '1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_MAX - 1'b1;

  state_t           state_reg;
  logic             owner_reg;
  logic             last_grant_reg;
  logic             squash_reg;
  logic [TMO_W-1:0] wait_cnt_reg;

  logic [AW-1:0]    m_addr_reg;
  logic [DW-1:0]    m_wdata_reg;
  logic             m_rd_reg;
  logic             m_wr_reg;
  logic             m_halt_reg;
  logic [DW-1:0]    if_rdata_reg;
  logic             if_done_reg;
  logic [DW-1:0]    mem_rdata_reg;
  logic             mem_done_reg;
  logic             err_reg;

  logic mem_req;
  logic mem_conflict;
  logic grant_mem;
  logic grant_if;
  logic timed_out;
  logic completing;

  assign mem_req      = bus.mem_rd | bus.mem_wr;
  assign mem_conflict = bus.mem_rd & bus.mem_wr;

  // MEM normally wins; IF wins a tie only right after a MEM transaction.
  assign grant_mem = mem_req & ~mem_conflict & ~(bus.if_req & (last_grant_reg == OWN_MEM));
  assign grant_if  = bus.if_req & ~mem_conflict & ~grant_mem;

  assign timed_out  = (wait_cnt_reg == TMO_MAX);
  assign completing = ((state_reg == ST_ISSUE) & ~bus.m_busy & bus.m_done) |
                      ((state_reg == ST_WAIT) & bus.m_done);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= ST_IDLE;
      owner_reg      <= OWN_IF;
      last_grant_reg <= OWN_IF;
      squash_reg     <= 1'b0;
      wait_cnt_reg   <= '0;
      m_addr_reg     <= '0;
      m_wdata_reg    <= '0;
      m_rd_reg       <= 1'b0;
      m_wr_reg       <= 1'b0;
      m_halt_reg     <= 1'b0;
      if_rdata_reg   <= '0;
      if_done_reg    <= 1'b0;
      mem_rdata_reg  <= '0;
      mem_done_reg   <= 1'b0;
      err_reg        <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          wait_cnt_reg <= '0;
          squash_reg   <= 1'b0;
          if (bus.m_done || mem_conflict) begin
            err_reg <= 1'b1;
          end
          if (!m_halt_reg) begin
            if (bus.halt) begin
              m_halt_reg <= 1'b1;
            end else if (grant_mem) begin
              owner_reg   <= OWN_MEM;
              m_addr_reg  <= bus.mem_addr;
              m_wdata_reg <= bus.mem_wdata;
              m_rd_reg    <= bus.mem_rd;
              m_wr_reg    <= bus.mem_wr;
              state_reg   <= ST_ISSUE;
            end else if (grant_if) begin
              owner_reg  <= OWN_IF;
              m_addr_reg <= bus.if_addr;
              m_rd_reg   <= 1'b1;
              m_wr_reg   <= 1'b0;
              state_reg  <= ST_ISSUE;
            end
          end
        end

        ST_ISSUE, ST_WAIT: begin
          // Once the wait counter saturates the arbiter stays frozen until reset.
          if (!timed_out) begin
            if ((owner_reg == OWN_MEM) && !mem_req) begin
              err_reg <= 1'b1;
            end
            if ((owner_reg == OWN_IF) && !bus.if_req) begin
              squash_reg <= 1'b1;
            end
            if (state_reg == ST_ISSUE) begin
              if (!bus.m_busy) begin
                m_rd_reg <= 1'b0;
                m_wr_reg <= 1'b0;
              end else if (bus.m_done) begin
                err_reg <= 1'b1;
              end
            end
            if (completing) begin
              state_reg <= ST_RESP;
              if (owner_reg == OWN_MEM) begin
                mem_rdata_reg <= bus.m_rdata;
                mem_done_reg  <= 1'b1;
              end else if (bus.if_req && !squash_reg) begin
                if_rdata_reg <= bus.m_rdata;
                if_done_reg  <= 1'b1;
              end
            end else begin
              if ((state_reg == ST_ISSUE) && !bus.m_busy) begin
                state_reg <= ST_WAIT;
              end
              wait_cnt_reg <= wait_cnt_reg + 1'b1;
              if (wait_cnt_reg == TMO_LAST) begin
                err_reg <= 1'b1;
              end
            end
          end
        end

        ST_RESP: begin
          if_done_reg    <= 1'b0;
          mem_done_reg   <= 1'b0;
          last_grant_reg <= owner_reg;
          if (bus.m_done) begin
            err_reg <= 1'b1;
          end
          state_reg <= ST_IDLE;
        end

        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.m_addr    = m_addr_reg;
  assign bus.m_wdata   = m_wdata_reg;
  assign bus.m_rd      = m_rd_reg;
  assign bus.m_wr      = m_wr_reg;
  assign bus.m_halt    = m_halt_reg;
  assign bus.if_rdata  = if_rdata_reg;
  assign bus.if_done   = if_done_reg;
  assign bus.mem_rdata = mem_rdata_reg;
  assign bus.mem_done  = mem_done_reg;
  assign bus.err       = err_reg;

  assign bus.if_stall  = bus.if_req & ~if_done_reg;
  assign bus.mem_stall = mem_req & ~mem_done_reg;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: directed scenarios plus randomized IF/MEM
// traffic against a reference memory image and a reactive memory model.
module tb_mem_port_arbiter;

  logic clk;
  logic rst_n;

  mem_port_arbiter_if #(.AW(16), .DW(16)) bus ();

  mem_port_arbiter #(.AW(16), .DW(16), .TMO_W(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    logic        is_rd;
    logic [15:0] data;
  } exp_t;

  typedef struct packed {
    logic        wr;
    logic [15:0] addr;
    logic [15:0] wdata;
  } acc_t;

  int n_checks = 0;
  int n_pass   = 0;

  logic [15:0] if_exp_q[$];
  exp_t        mem_exp_q[$];
  acc_t        acc_q[$];
  logic [15:0] ref_mem [256];

  // memory model configuration
  int          busy_force = 0;   // -1: random busy cycles
  int          lat_force  = 1;   // -1: random done latency
  bit          withhold   = 1'b0;
  bit          rdata_force_en = 1'b0;
  logic [15:0] rdata_force = '0;
  int          stray_req  = 0;

  function automatic logic [15:0] init_val(input int a);
    logic [15:0] v;
    v = 16'(a * 40503) ^ 16'h5A5A;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reactive memory: busy for a chosen number of cycles, then accepts and answers after a latency.
  task automatic responder();
    int          lat_cnt = 0;
    int          busy_left = 0;
    int          stray_seen = 0;
    int          l;
    bit          in_cmd = 1'b0;
    logic [15:0] rd_hold = '0;
    logic [15:0] mem_arr [256];
    for (int i = 0; i < 256; i++) mem_arr[i] = init_val(i);
    forever begin
      tick();
      bus.m_done = 1'b0;
      bus.m_busy = 1'b0;
      if (!rst_n) begin
        lat_cnt = 0;
        in_cmd  = 1'b0;
      end else if (stray_req != stray_seen) begin
        stray_seen   = stray_req;
        bus.m_done   = 1'b1;
        bus.m_rdata  = 16'hDEAD;
      end else if (lat_cnt > 0) begin
        lat_cnt--;
        if (lat_cnt == 0) begin
          bus.m_done  = 1'b1;
          bus.m_rdata = rd_hold;
        end
      end else if (bus.m_rd || bus.m_wr) begin
        if (!in_cmd) begin
          in_cmd    = 1'b1;
          busy_left = (busy_force >= 0) ? busy_force : int'($urandom_range(0, 3));
        end
        if (busy_left > 0) begin
          bus.m_busy = 1'b1;
          busy_left--;
        end else begin
          in_cmd = 1'b0;
          acc_q.push_back('{wr: bus.m_wr, addr: bus.m_addr, wdata: bus.m_wdata});
          if (bus.m_wr) mem_arr[bus.m_addr[7:0]] = bus.m_wdata;
          rd_hold = rdata_force_en ? rdata_force : mem_arr[bus.m_addr[7:0]];
          if (!withhold) begin
            l = (lat_force >= 0) ? lat_force : int'($urandom_range(0, 3));
            if (l == 0) begin
              bus.m_done  = 1'b1;
              bus.m_rdata = rd_hold;
            end else begin
              lat_cnt = l;
            end
          end
        end
      end
    end
  endtask

  // Pops the expected response whenever a done pulse is presented.
  task automatic monitor();
    logic [15:0] e;
    exp_t        me;
    forever begin
      @(negedge clk);
      if (bus.if_done) begin
        if (if_exp_q.size() == 0) check("if_done_unexpected", bus.if_done, 1'b0);
        else begin
          e = if_exp_q.pop_front();
          $display("[%0t] IF  read  rdata=%h expected=%h", $time, bus.if_rdata, e);
          check("if_rdata", bus.if_rdata, e);
        end
      end
      if (bus.mem_done) begin
        if (mem_exp_q.size() == 0) check("mem_done_unexpected", bus.mem_done, 1'b0);
        else begin
          me = mem_exp_q.pop_front();
          $display("[%0t] MEM %s rdata=%h", $time, me.is_rd ? "read " : "write", bus.mem_rdata);
          if (me.is_rd) check("mem_rdata", bus.mem_rdata, me.data);
        end
      end
    end
  endtask

  task automatic do_reset();
    bus.if_req = 1'b0; bus.mem_rd = 1'b0; bus.mem_wr = 1'b0; bus.halt = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_ctrl", {bus.m_rd, bus.m_wr, bus.m_halt, bus.if_done, bus.mem_done, bus.err}, '0);
    check("reset_data", {bus.m_addr, bus.m_wdata, bus.if_rdata, bus.mem_rdata}, '0);
    rst_n = 1'b1;
  endtask

  task automatic wait_if_done(input int maxc, output bit seen);
    seen = 1'b0;
    for (int c = 0; c < maxc && !seen; c++) begin
      tick();
      if (bus.if_done) seen = 1'b1;
    end
  endtask

  initial begin
    bit          seen;
    bit          if_pending;
    bit          issued;
    int          mem_phase;
    int          n0;
    logic [15:0] prev_if_rdata;

    rst_n = 1'b0;
    bus.if_req = 1'b0; bus.if_addr = '0;
    bus.mem_rd = 1'b0; bus.mem_wr = 1'b0; bus.mem_addr = '0; bus.mem_wdata = '0;
    bus.halt = 1'b0; bus.m_rdata = '0; bus.m_busy = 1'b0; bus.m_done = 1'b0;
    for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);

    fork
      responder();
      monitor();
    join_none

    do_reset();

    // IF-only read, exact latency
    rdata_force_en = 1'b1; rdata_force = 16'hBEEF; lat_force = 1; busy_force = 0;
    tick();
    bus.if_req = 1'b1; bus.if_addr = 16'h0010;
    if_exp_q.push_back(16'hBEEF);
    tick();
    check("if_only_issue", {bus.m_rd, bus.m_wr, bus.m_addr}, {1'b1, 1'b0, 16'h0010});
    check("if_only_stall_high", bus.if_stall, 1'b1);
    tick();
    check("if_only_rd_pulse", {bus.m_rd, bus.if_done}, 2'b00);
    tick();
    check("if_only_done", bus.if_done, 1'b1);
    check("if_only_stall_low", bus.if_stall, 1'b0);
    bus.if_req = 1'b0;
    tick();
    check("if_only_done_one_cycle", {bus.if_done, bus.m_rd}, 2'b00);
    rdata_force_en = 1'b0;

    // Contention: MEM write first, then IF, then the follow-up MEM read
    acc_q.delete();
    lat_force = 0;
    bus.if_req = 1'b1; bus.if_addr = 16'h0020;
    if_exp_q.push_back(ref_mem[8'h20]);
    bus.mem_wr = 1'b1; bus.mem_addr = 16'h0040; bus.mem_wdata = 16'h1234;
    ref_mem[8'h40] = 16'h1234;
    mem_exp_q.push_back('{is_rd: 1'b0, data: 16'h0});
    mem_phase = 0; if_pending = 1'b1;
    for (int c = 0; c < 60 && (mem_phase < 2 || if_pending); c++) begin
      tick();
      if (bus.mem_done) begin
        if (mem_phase == 0) begin
          bus.mem_wr = 1'b0; bus.mem_rd = 1'b1; bus.mem_addr = 16'h0040;
          mem_exp_q.push_back('{is_rd: 1'b1, data: 16'h1234});
        end else begin
          bus.mem_rd = 1'b0;
        end
        mem_phase++;
      end
      if (bus.if_done) begin
        bus.if_req = 1'b0;
        if_pending = 1'b0;
      end
    end
    check("contention_complete", {mem_phase[3:0], if_pending}, {4'd2, 1'b0});
    check("contention_count", acc_q.size(), 3);
    if (acc_q.size() == 3) begin
      check("contention_first_mem_wr", acc_q[0], {1'b1, 16'h0040, 16'h1234});
      check("contention_second_if", {acc_q[1].wr, acc_q[1].addr}, {1'b0, 16'h0020});
      check("contention_third_mem_rd", {acc_q[2].wr, acc_q[2].addr}, {1'b0, 16'h0040});
    end

    // Busy memory: command held for 4 busy cycles, accepted on the 5th
    tick();
    busy_force = 4; lat_force = 1;
    bus.if_req = 1'b1; bus.if_addr = 16'h0030;
    if_exp_q.push_back(ref_mem[8'h30]);
    tick();
    for (int k = 0; k < 5; k++) begin
      check("busy_hold", {bus.m_rd, bus.m_addr}, {1'b1, 16'h0030});
      tick();
    end
    check("busy_released", bus.m_rd, 1'b0);
    wait_if_done(10, seen);
    check("busy_done_seen", seen, 1'b1);
    bus.if_req = 1'b0;
    check("busy_no_err", bus.err, 1'b0);
    busy_force = 0;

    // Squash: IF drops its request after the grant
    tick();
    acc_q.delete();
    prev_if_rdata = bus.if_rdata;
    lat_force = 3;
    bus.if_req = 1'b1; bus.if_addr = 16'h0050;
    tick();
    bus.if_req = 1'b0;
    repeat (8) tick();
    check("squash_mem_completed", acc_q.size(), 1);
    check("squash_rdata_kept", bus.if_rdata, prev_if_rdata);
    check("squash_idle", {bus.m_rd, bus.if_done, bus.err}, 3'b000);

    // Randomized traffic
    busy_force = -1; lat_force = -1;
    fork
      begin : if_proc
        bit s;
        int a;
        for (int t = 0; t < 40; t++) begin
          repeat ($urandom_range(0, 3)) tick();
          a = int'($urandom_range(0, 127));
          bus.if_addr = 16'(a);
          bus.if_req  = 1'b1;
          if_exp_q.push_back(ref_mem[a]);
          wait_if_done(300, s);
          bus.if_req = 1'b0;
          check("rand_if_done_seen", s, 1'b1);
        end
      end
      begin : mem_proc
        bit          s;
        int          a;
        logic [15:0] d;
        for (int t = 0; t < 40; t++) begin
          repeat ($urandom_range(0, 3)) tick();
          a = int'($urandom_range(128, 255));
          bus.mem_addr = 16'(a);
          if ($urandom_range(0, 1) == 1) begin
            d = 16'($urandom);
            bus.mem_wdata = d;
            bus.mem_wr = 1'b1;
            ref_mem[a] = d;
            mem_exp_q.push_back('{is_rd: 1'b0, data: 16'h0});
          end else begin
            bus.mem_rd = 1'b1;
            mem_exp_q.push_back('{is_rd: 1'b1, data: ref_mem[a]});
          end
          s = 1'b0;
          for (int c = 0; c < 300 && !s; c++) begin
            tick();
            if (bus.mem_done) s = 1'b1;
          end
          bus.mem_rd = 1'b0; bus.mem_wr = 1'b0;
          check("rand_mem_done_seen", s, 1'b1);
        end
      end
    join
    repeat (3) tick();
    check("rand_no_err", bus.err, 1'b0);
    check("scoreboard_drained", {if_exp_q.size(), mem_exp_q.size()}, 64'h0);
    busy_force = 0; lat_force = 1;

    // MEM read+write together: no grant, err
    acc_q.delete();
    bus.mem_rd = 1'b1; bus.mem_wr = 1'b1; bus.mem_addr = 16'h0088;
    tick();
    check("conflict_err", bus.err, 1'b1);
    check("conflict_no_cmd", {bus.m_rd, bus.m_wr}, 2'b00);
    bus.mem_rd = 1'b0; bus.mem_wr = 1'b0;
    tick();
    check("conflict_no_accept", acc_q.size(), 0);

    // Timeout with m_done withheld
    do_reset();
    withhold = 1'b1;
    tick();
    bus.if_req = 1'b1; bus.if_addr = 16'h0060;
    tick();
    repeat (28) tick();
    check("timeout_not_early", bus.err, 1'b0);
    seen = 1'b0;
    for (int c = 0; c < 6 && !seen; c++) begin
      tick();
      if (bus.err) seen = 1'b1;
    end
    check("timeout_err", seen, 1'b1);

    // Asynchronous reset while stuck in WAIT
    bus.if_req = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    check("async_reset_ctrl", {bus.m_rd, bus.m_wr, bus.m_halt, bus.if_done, bus.mem_done, bus.err}, '0);
    check("async_reset_data", {bus.m_addr, bus.m_wdata, bus.if_rdata, bus.mem_rdata}, '0);
    withhold = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();

    // Stray m_done in IDLE
    stray_req++;
    repeat (2) tick();
    check("stray_ignored", {bus.if_done, bus.mem_done, bus.m_rd, bus.m_wr}, 4'b0000);
    check("stray_err", bus.err, 1'b1);

    // Halt in IDLE, then no further commands
    bus.halt = 1'b1;
    tick();
    check("halt_set", bus.m_halt, 1'b1);
    bus.halt = 1'b0;
    n0 = acc_q.size();
    bus.if_req = 1'b1; bus.if_addr = 16'h0011;
    bus.mem_rd = 1'b1; bus.mem_addr = 16'h0090;
    issued = 1'b0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (bus.m_rd || bus.m_wr) issued = 1'b1;
    end
    check("halt_no_cmd", issued, 1'b0);
    check("halt_no_accept", acc_q.size(), n0);
    check("halt_sticky", bus.m_halt, 1'b1);
    bus.if_req = 1'b0; bus.mem_rd = 1'b0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
